lm07_poll_scheduler: RTL and testbench

//  Sequencer for the LM07 3-wire SPI temperature sensor. Drives CS/SCK from

---
 rtl/lm07_poll_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_lm07_poll_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm07_poll_scheduler.sv
// LM07 3-wire SPI read sequencer: poll timer / on-demand trigger, CS/SCK generation,
// frame capture and latch of the last complete reading.
module lm07_poll_scheduler #(
  parameter int unsigned SCK_DIV     = 2,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned NBITS       = 16,
  parameter int unsigned POLL_PERIOD = 1000
) (
  input  logic             SYSCLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             REQ,
  input  logic             SIO,
  output logic             CS,
  output logic             SCK,
  output logic             BUSY,
  output logic [NBITS-1:0] RAW,
  output logic [7:0]       DATA_OUT,
  output logic             VALID,
  output logic             OVERRUN
);

  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned DW = $clog2(SCK_DIV + 1);
  localparam int unsigned SW = $clog2(CS_SETUP + 1);
  localparam int unsigned PW = $clog2(POLL_PERIOD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      poll_q, poll_d;
  logic [SW-1:0]      setup_cnt_q, setup_cnt_d;
  logic [DW-1:0]      div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               phase_q, phase_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [NBITS-1:0]   raw_q, raw_d;
  logic [7:0]         data_q, data_d;
  logic               tick_c;
  logic               trig_c;

  // Free-running poll timer, parked at zero while polling is disabled.
  always_comb begin
    tick_c = EN && (poll_q == PW'(POLL_PERIOD - 1));
    trig_c = tick_c || REQ;
    poll_d = poll_q + PW'(1);
    if (!EN || tick_c) begin
      poll_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    raw_d       = raw_q;
    data_d      = data_q;

    // A single trigger can wait behind the active frame; a second one is lost.
    if (state_q != IDLE && trig_c) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trig_c || pending_q) begin
          state_d     = SETUP;
          setup_cnt_d = '0;
          pending_d   = 1'b0;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      SHIFT: begin
        if (div_q == DW'(SCK_DIV - 1)) begin
          div_d   = '0;
          phase_d = !phase_q;
          // Low phase ending: this edge raises SCK, so capture SIO now.
          if (!phase_q) begin
            shift_d = {shift_q[NBITS-2:0], SIO};
          end else if (bit_q == BW'(NBITS - 1)) begin
            state_d     = HOLD;
            setup_cnt_d = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (setup_cnt_q == SW'(CS_SETUP - 1)) begin
          state_d = DONE;
          raw_d   = shift_q;
          data_d  = shift_q[NBITS-1 -: 8];
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin-level outputs are registered images of the next state.
  always_comb begin
    cs_d    = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    sck_d   = !(state_d == SHIFT && !phase_d);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q     <= IDLE;
      poll_q      <= '0;
      setup_cnt_q <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      raw_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      poll_q      <= poll_d;
      setup_cnt_q <= setup_cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      raw_q       <= raw_d;
      data_q      <= data_d;
    end
  end

  assign CS       = cs_q;
  assign SCK      = sck_q;
  assign BUSY     = busy_q;
  assign RAW      = raw_q;
  assign DATA_OUT = data_q;
  assign VALID    = valid_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_lm07_poll_scheduler.sv
// Bench for lm07_poll_scheduler: sensor model on the SPI pins, frame-level reference
// model for trigger/pending/overrun scheduling, plus a small-configuration instance.
module tb_lm07_poll_scheduler;

  localparam int SCK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int NB       = 16;
  localparam int POLL     = 100;
  localparam int LOW_LEN  = 2 * CS_SETUP + 2 * SCK_DIV * NB;
  localparam int LOW_LEN2 = 2 * 1 + 2 * 1 * 9;

  logic clk = 1'b0;
  logic rst, en, req, sio;
  logic cs, sck, busy, valid, overrun;
  logic [15:0] raw;
  logic [7:0]  dout;

  logic en2, req2, sio2;
  logic cs2, sck2, busy2, valid2, overrun2;
  logic [8:0] raw2;
  logic [7:0] dout2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lm07_poll_scheduler #(.SCK_DIV(SCK_DIV), .CS_SETUP(CS_SETUP), .NBITS(NB), .POLL_PERIOD(POLL)) dut (
    .SYSCLK(clk), .RST(rst), .EN(en), .REQ(req), .SIO(sio),
    .CS(cs), .SCK(sck), .BUSY(busy), .RAW(raw), .DATA_OUT(dout),
    .VALID(valid), .OVERRUN(overrun)
  );

  lm07_poll_scheduler #(.SCK_DIV(1), .CS_SETUP(1), .NBITS(9), .POLL_PERIOD(50)) dut2 (
    .SYSCLK(clk), .RST(rst), .EN(en2), .REQ(req2), .SIO(sio2),
    .CS(cs2), .SCK(sck2), .BUSY(busy2), .RAW(raw2), .DATA_OUT(dout2),
    .VALID(valid2), .OVERRUN(overrun2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model and frame recorder for the main instance.
  logic [15:0] send_q[$];
  logic [15:0] exp_q[$];
  int          start_q[$];
  int          len_q[$];
  int          rises_q[$];
  logic [15:0] raw_q[$];
  logic [7:0]  dout_q[$];
  logic [15:0] cur_word = '0;
  int          rise_cnt = 0;
  int          low_cnt = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b1;

  assign sio = (rise_cnt < NB) ? cur_word[4'(15 - rise_cnt)] : 1'b0;

  always @(negedge clk) begin
    automatic logic [15:0] w;
    prev_cs  <= cs;
    prev_sck <= sck;
    if (prev_cs && !cs) begin
      if (send_q.size() > 0) w = send_q.pop_front();
      else w = 16'($urandom);
      cur_word <= w;
      exp_q.push_back(w);
      start_q.push_back(cyc);
      low_cnt  <= 1;
      rise_cnt <= 0;
    end else begin
      if (!cs) low_cnt <= low_cnt + 1;
      if (!cs && !prev_sck && sck) rise_cnt <= rise_cnt + 1;
    end
    if (!prev_cs && cs) begin
      len_q.push_back(low_cnt);
      rises_q.push_back(rise_cnt);
    end
    if (valid) begin
      raw_q.push_back(raw);
      dout_q.push_back(dout);
    end
  end

  task automatic flush();
    start_q.delete(); len_q.delete(); rises_q.delete();
    raw_q.delete(); dout_q.delete(); exp_q.delete(); send_q.delete();
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cs !== 1'b1 || sck !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_pins got cs=%b sck=%b busy=%b exp 1 1 0", cs, sck, busy); end
    checks++; if (raw !== 16'h0 || dout !== 8'h0 || valid !== 1'b0 || overrun !== 1'b0) begin errors++;
      $display("FAIL reset_data got raw=%h dout=%h valid=%b ovr=%b exp 0", raw, dout, valid, overrun); end
    checks++; if (cs2 !== 1'b1 || sck2 !== 1'b1 || raw2 !== 9'h0 || valid2 !== 1'b0) begin errors++;
      $display("FAIL reset_small got cs=%b sck=%b raw=%h valid=%b", cs2, sck2, raw2, valid2); end
  endtask

  task automatic test_single_req();
    int c;
    flush();
    send_q.push_back(16'hA5C3);
    c = cyc;
    pulse_req();
    for (int i = 0; i < 200 && raw_q.size() == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (start_q.size() != 1 || start_q[0] != c + 1) begin errors++;
      $display("FAIL t2_start got n=%0d first=%0d exp 1 at %0d", start_q.size(),
               (start_q.size() > 0) ? start_q[0] : -1, c + 1); end
    checks++; if (len_q.size() != 1 || len_q[0] != LOW_LEN) begin errors++;
      $display("FAIL t2_cs_low got n=%0d len=%0d exp %0d", len_q.size(), (len_q.size() > 0) ? len_q[0] : -1, LOW_LEN); end
    checks++; if (rises_q.size() != 1 || rises_q[0] != NB) begin errors++;
      $display("FAIL t2_sck_rises got %0d exp %0d", (rises_q.size() > 0) ? rises_q[0] : -1, NB); end
    checks++; if (raw_q.size() != 1 || raw_q[0] !== 16'hA5C3 || dout_q[0] !== 8'hA5) begin errors++;
      $display("FAIL t2_data got valids=%0d raw=%h dout=%h exp 1 A5C3 A5", raw_q.size(),
               (raw_q.size() > 0) ? raw_q[0] : 16'h0, (dout_q.size() > 0) ? dout_q[0] : 8'h0); end
    checks++; if (raw !== 16'hA5C3 || busy !== 1'b0 || cs !== 1'b1 || sck !== 1'b1) begin errors++;
      $display("FAIL t2_hold got raw=%h busy=%b cs=%b sck=%b exp A5C3 0 1 1", raw, busy, cs, sck); end
  endtask

  task automatic test_reset_midframe();
    flush();
    pulse_req();
    repeat (20) @(negedge clk);
    checks++; if (cs !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL t1_inframe got cs=%b busy=%b exp 0 1", cs, busy); end
    req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    checks++; if (cs !== 1'b1 || sck !== 1'b1 || raw !== 16'h0 || valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h0) begin
      errors++; $display("FAIL t1_reset got cs=%b sck=%b raw=%h valid=%b busy=%b dout=%h", cs, sck, raw, valid, busy, dout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    flush();
    repeat (20) @(negedge clk);
    checks++; if (start_q.size() != 0 || raw_q.size() != 0 || cs !== 1'b1) begin errors++;
      $display("FAIL t1_after got starts=%0d valids=%0d cs=%b exp 0 0 1", start_q.size(), raw_q.size(), cs); end
  endtask

  task automatic test_poll();
    int c0;
    flush();
    send_q.push_back(16'h1900);
    send_q.push_back(16'h3280);
    en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 320 && raw_q.size() < 2; i++) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (start_q.size() != 2) begin errors++;
      $display("FAIL t3_nframes got %0d exp 2", start_q.size()); end
    else begin
      checks++; if (start_q[0] != c0 + POLL || start_q[1] != c0 + 2 * POLL) begin errors++;
        $display("FAIL t3_period got %0d %0d exp %0d %0d", start_q[0], start_q[1], c0 + POLL, c0 + 2 * POLL); end
    end
    checks++; if (raw_q.size() != 2) begin errors++;
      $display("FAIL t3_nvalid got %0d exp 2", raw_q.size()); end
    else begin
      checks++; if (raw_q[0] !== 16'h1900 || raw_q[1] !== 16'h3280 || dout_q[0] !== 8'h19 || dout_q[1] !== 8'h32) begin
        errors++; $display("FAIL t3_data got %h/%h %h/%h exp 1900/19 3280/32", raw_q[0], dout_q[0], raw_q[1], dout_q[1]); end
    end
  endtask

  task automatic test_pending();
    flush();
    pulse_req();
    @(negedge clk);
    pulse_req();
    repeat (200) @(negedge clk);
    checks++; if (start_q.size() != 2 || (start_q[1] - start_q[0]) != LOW_LEN + 2) begin errors++;
      $display("FAIL t4_pending got n=%0d gap=%0d exp 2 gap %0d", start_q.size(),
               (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, LOW_LEN + 2); end
    checks++; if (overrun !== 1'b0 || raw_q.size() != 2) begin errors++;
      $display("FAIL t4_no_overrun got ovr=%b valids=%0d exp 0 2", overrun, raw_q.size()); end
    flush();
    pulse_req();
    repeat (10) @(negedge clk);
    pulse_req();
    repeat (20) @(negedge clk);
    pulse_req();
    repeat (250) @(negedge clk);
    checks++; if (start_q.size() != 2 || raw_q.size() != 2) begin errors++;
      $display("FAIL t4_one_extra got starts=%0d valids=%0d exp 2 2", start_q.size(), raw_q.size()); end
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL t4_overrun got %b exp 1", overrun); end
  endtask

  task automatic test_en_drop();
    flush();
    en = 1'b1;
    for (int i = 0; i < 150 && start_q.size() == 0; i++) @(negedge clk);
    repeat (2 * CS_SETUP + 5 * 2 * SCK_DIV) @(negedge clk);
    en = 1'b0;
    checks++; if (busy !== 1'b1 || cs !== 1'b0) begin errors++;
      $display("FAIL t5_midframe got busy=%b cs=%b exp 1 0", busy, cs); end
    repeat (300) @(negedge clk);
    checks++; if (start_q.size() != 1 || raw_q.size() != 1) begin errors++;
      $display("FAIL t5_frames got starts=%0d valids=%0d exp 1 1", start_q.size(), raw_q.size()); end
    else begin
      checks++; if (raw_q[0] !== exp_q[0] || len_q[0] != LOW_LEN) begin errors++;
        $display("FAIL t5_data got raw=%h len=%0d exp %h %0d", raw_q[0], len_q[0], exp_q[0], LOW_LEN); end
    end
  endtask

  // Frame-level scheduler model: a frame holds CS low LOW_LEN cycles, then DONE and
  // one IDLE cycle; triggers seen while not idle queue at most one follow-up frame.
  task automatic test_random();
    int trig[$];
    int exp_starts[$];
    int base, s, k, n;
    bit pend, ovr, t;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    flush();
    n = 700;
    base = cyc + 1;
    for (int i = 0; i < n; i++) begin
      req = ($urandom_range(0, 39) == 0);
      if (req) trig.push_back(cyc + 1);
      @(negedge clk);
    end
    req = 1'b0;
    repeat (200) @(negedge clk);

    s = -1000; k = 0; pend = 1'b0; ovr = 1'b0;
    for (int e = base; e < base + n + 200; e++) begin
      t = (k < trig.size()) && (trig[k] == e);
      if (t) k++;
      if (e >= s + LOW_LEN + 2) begin
        if (t || pend) begin
          s = e;
          pend = 1'b0;
          exp_starts.push_back(e);
        end
      end else if (t) begin
        if (pend) ovr = 1'b1;
        pend = 1'b1;
      end
    end

    checks++; if (start_q.size() != exp_starts.size() || raw_q.size() != exp_starts.size()) begin errors++;
      $display("FAIL rnd_count got starts=%0d valids=%0d exp %0d", start_q.size(), raw_q.size(), exp_starts.size()); end
    else begin
      for (int i = 0; i < exp_starts.size(); i++) begin
        checks++; if (start_q[i] != exp_starts[i] || len_q[i] != LOW_LEN) begin errors++;
          $display("FAIL rnd_start[%0d] got %0d len %0d exp %0d len %0d", i, start_q[i], len_q[i], exp_starts[i], LOW_LEN); end
        checks++; if (raw_q[i] !== exp_q[i] || dout_q[i] !== exp_q[i][15:8]) begin errors++;
          $display("FAIL rnd_data[%0d] got %h/%h exp %h/%h", i, raw_q[i], dout_q[i], exp_q[i], exp_q[i][15:8]); end
      end
    end
    checks++; if (overrun !== ovr) begin errors++;
      $display("FAIL rnd_overrun got %b exp %b", overrun, ovr); end
  endtask

  task automatic test_small_cfg();
    logic [8:0] w, got;
    logic [7:0] gd;
    int low, rises, vcnt;
    logic psck;
    for (int f = 0; f < 3; f++) begin
      w = (f == 0) ? 9'h1FF : 9'($urandom);
      low = 0; rises = 0; vcnt = 0; psck = 1'b1; got = '0; gd = '0;
      sio2 = w[8];
      req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (!cs2) low++;
        if (!cs2 && !psck && sck2) rises++;
        psck = sck2;
        if (valid2) begin vcnt++; got = raw2; gd = dout2; end
        sio2 = (rises < 9) ? w[4'(8 - rises)] : 1'b0;
        @(negedge clk);
      end
      checks++; if (low != LOW_LEN2 || rises != 9) begin errors++;
        $display("FAIL t6_timing[%0d] got low=%0d rises=%0d exp %0d 9", f, low, rises, LOW_LEN2); end
      checks++; if (vcnt != 1 || got !== w || gd !== w[8:1] || raw2 !== w) begin errors++;
        $display("FAIL t6_data[%0d] got valids=%0d raw=%h dout=%h exp 1 %h %h", f, vcnt, got, gd, w, w[8:1]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 1'b0;
    en2 = 1'b0; req2 = 1'b0; sio2 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_single_req();
    test_reset_midframe();
    test_poll();
    test_pending();
    test_en_drop();
    test_random();
    test_small_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
